pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: PC_WIDTH, default 32, width of pc and all address/target ports.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  leave IDLE or HALT and begin fetching.
REQ-006 Port: imem_req  output  1  fetch request to instruction memory.
REQ-007 Port: imem_addr  output  32  fetch address; always equals pc.
REQ-008 Port: imem_ack  input  1  fetch complete; honoured only in FETCH.
REQ-009 Port: instr_valid  output  1  fetched instruction available to execute.
REQ-010 Port: branch_req  input  1  relative branch request.
REQ-011 Port: branch_offset  input  8  signed two's-complement branch displacement.
REQ-012 Port: jump_req  input  1  absolute jump request.
REQ-013 Port: jump_target  input  32  absolute jump destination.
REQ-014 Port: stall  input  1  hold the current instruction and pc.
REQ-015 Port: halt_req  input  1  stop sequencing after the current instruction.
REQ-016 Port: pc  output  32  current program counter.
REQ-017 Port: state  output  2  current FSM state, for debug.

Function
REQ-018 States SHALL be IDLE=0, FETCH=1, ISSUE=2, HALT=3.
REQ-019 IDLE: imem_req=0, instr_valid=0; start -> FETCH on the next edge.
REQ-020 FETCH: imem_req=1; imem_ack -> ISSUE on the next edge; no ack -> remain in FETCH, request held, imem_addr stable.
REQ-021 ISSUE: instr_valid=1 for every cycle spent in ISSUE; imem_req=0.
REQ-022 ISSUE SHALL resolve control with priority halt_req > stall > jump_req > branch_req > increment.
REQ-023 halt_req: pc unchanged; next state HALT.
REQ-024 stall: pc unchanged; remain in ISSUE.
REQ-025 jump_req: pc <= jump_target; next state FETCH.
REQ-026 branch_req: pc <= pc + sign-extended branch_offset; next state FETCH.
REQ-027 Otherwise: pc <= pc + 1; next state FETCH.
REQ-028 All pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFF + 1 = 0, and 0 + (-1) = 32'hFFFF_FFFF.
REQ-029 HALT: imem_req=0, instr_valid=0, pc held; start -> FETCH.
REQ-030 imem_ack outside FETCH, and branch/jump/stall/halt inputs outside ISSUE, SHALL be ignored.
REQ-031 start SHALL be ignored in FETCH and ISSUE.
REQ-032 Minimum fetch-to-fetch spacing SHALL be 2 cycles (FETCH with immediate ack, then ISSUE).

Reset
REQ-033 Assertion of reset SHALL force state=IDLE, pc=RESET_VECTOR, imem_req=0 and instr_valid=0 immediately, without waiting for a clock edge, including during FETCH or ISSUE.
REQ-034 After reset deasserts, the block SHALL remain in IDLE until start is sampled high.

Structure
REQ-035 Package pc_seq_pkg SHALL hold the state enum typedef, PC_WIDTH, the default RESET_VECTOR and the state encodings.
REQ-036 A combinational sub-module pc_next_calc SHALL compute the next pc (select, sign-extend, add); the FSM and pc register SHALL stay in pc_sequencer.

Verification
REQ-037 Reset, start, ack on every fetch -> imem_addr sequence 0,1,2,3 with instr_valid pulsing every 2nd cycle.
REQ-038 pc=8'h10 in ISSUE, branch_req with offset 8'hF0 (-16) -> next fetch address 0x0000_0000; offset 8'h7F -> 0x0000_008F.
REQ-039 jump_req and branch_req both high, jump_target=0x1234_5678 -> next fetch address 0x1234_5678; with stall also high -> pc unchanged, state stays ISSUE.
REQ-040 pc=0xFFFF_FFFF, plain increment -> next fetch address 0x0000_0000.
REQ-041 imem_ack withheld 5 cycles -> imem_req held and imem_addr stable throughout; reset asserted mid-FETCH -> imem_req=0 and pc=RESET_VECTOR before the next edge.
REQ-042 halt_req in ISSUE -> HALT with pc held and stray imem_ack ignored; start -> FETCH at the same pc.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state encoding, next-pc source select and default geometry.
package pc_seq_pkg;

    localparam int          PC_WIDTH     = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        HALT  = ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc selection: hold, increment, relative branch or absolute jump.
// Arithmetic wraps naturally at PC_WIDTH bits.
module pc_next_calc #(
    parameter int PC_WIDTH = pc_seq_pkg::PC_WIDTH
) (
    input  pc_seq_pkg::pc_sel_e  sel,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [7:0]           branch_offset,
    input  logic [PC_WIDTH-1:0]  jump_target,
    output logic [PC_WIDTH-1:0]  next_pc
);
    import pc_seq_pkg::*;

    logic [PC_WIDTH-1:0] offset_ext_s;

    assign offset_ext_s = {{(PC_WIDTH-8){branch_offset[7]}}, branch_offset};

    // Select the next pc source
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_HOLD:   next_pc = pc;
            PC_INC:    next_pc = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            PC_BRANCH: next_pc = pc + offset_ext_s;
            PC_JUMP:   next_pc = jump_target;
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: walks IDLE/FETCH/ISSUE/HALT and owns the program counter.
// imem_req and instr_valid are registered from the next state so they track state exactly.
module pc_sequencer #(
    parameter int                RESET_VECTOR_W = 32,
    parameter int                PC_WIDTH       = pc_seq_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(pc_seq_pkg::RESET_VECTOR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    output logic                instr_valid,
    input  logic                branch_req,
    input  logic [7:0]          branch_offset,
    input  logic                jump_req,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                stall,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [1:0]          state
);
    import pc_seq_pkg::*;

    state_e              state_r;
    state_e              state_next_s;
    pc_sel_e             pc_sel_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_next_s;
    logic                imem_req_r;
    logic                instr_valid_r;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_calc (
        .sel           (pc_sel_s),
        .pc            (pc_r),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .next_pc       (pc_next_s)
    );

    // Next-state and pc-source decode; control inputs matter only in ISSUE
    always_comb begin
        state_next_s = state_r;
        pc_sel_s     = PC_HOLD;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = FETCH;
                else       state_next_s = IDLE;
            end
            FETCH: begin
                if (imem_ack) state_next_s = ISSUE;
                else          state_next_s = FETCH;
            end
            ISSUE: begin
                if (halt_req) begin
                    state_next_s = HALT;
                    pc_sel_s     = PC_HOLD;
                end else if (stall) begin
                    state_next_s = ISSUE;
                    pc_sel_s     = PC_HOLD;
                end else if (jump_req) begin
                    state_next_s = FETCH;
                    pc_sel_s     = PC_JUMP;
                end else if (branch_req) begin
                    state_next_s = FETCH;
                    pc_sel_s     = PC_BRANCH;
                end else begin
                    state_next_s = FETCH;
                    pc_sel_s     = PC_INC;
                end
            end
            HALT: begin
                if (start) state_next_s = FETCH;
                else       state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
                pc_sel_s     = PC_HOLD;
            end
        endcase
    end

    // State, pc and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= RESET_VECTOR;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            imem_req_r    <= (state_next_s == FETCH);
            instr_valid_r <= (state_next_s == ISSUE);
        end
    end

    assign imem_req    = imem_req_r;
    assign instr_valid = instr_valid_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign state       = state_r;

endmodule
